// File: rtl/regfile_arbiter.sv
// Two-requester (I2C / SPI) arbiter serialising read/write transactions onto a single-port register file.
// Optional statistics counters are compiled in when ARB_STATS_EN is defined; otherwise they read as 0.
module regfile_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int RD_LATENCY   = 1,
  parameter int SPI_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic [15:0]       grant_cnt_i2c,
  output logic [15:0]       grant_cnt_spi,
  output logic [15:0]       contention_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state, state_n;
  logic              gnt_spi, gnt_spi_n;
  logic              last_spi, last_spi_n;
  logic              we_q, we_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, i2c_rdata_n, spi_rdata_n;
  logic              wr_n, rd_n, i2c_ack_n, spi_ack_n;
  logic              pick_spi;

  // Every output is a register, so the combinational block computes the value each
  // output will hold in the *next* state (strobes land in ISSUE, acks land in ACK).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_n     = state;
    gnt_spi_n   = gnt_spi;
    last_spi_n  = last_spi;
    we_n        = we_q;
    cnt_n       = cnt;
    addr_n      = reg_addr;
    wdata_n     = reg_wdata;
    i2c_rdata_n = i2c_rdata;
    spi_rdata_n = spi_rdata;
    wr_n        = 1'b0;
    rd_n        = 1'b0;
    pick_spi    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i2c_req || spi_req) begin
          if (i2c_req && spi_req) pick_spi = (SPI_PRIORITY != 0) ? 1'b1 : !last_spi;
          else                    pick_spi = spi_req;
          gnt_spi_n = pick_spi;
          we_n      = pick_spi ? spi_we    : i2c_we;
          addr_n    = pick_spi ? spi_addr  : i2c_addr;
          wdata_n   = pick_spi ? spi_wdata : i2c_wdata;
          wr_n      = we_n;
          rd_n      = !we_n;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_n = ACK;
        end else begin
          cnt_n   = LAT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          if (gnt_spi) spi_rdata_n = reg_rdata;
          else         i2c_rdata_n = reg_rdata;
          state_n = ACK;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      ACK: begin
        last_spi_n = gnt_spi;
        state_n    = IDLE;
      end
    endcase
    i2c_ack_n = (state_n == ACK) && !gnt_spi_n;
    spi_ack_n = (state_n == ACK) && gnt_spi_n;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_spi   <= 1'b0;
      last_spi  <= 1'b1;
      we_q      <= 1'b0;
      cnt       <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      i2c_ack   <= 1'b0;
      spi_ack   <= 1'b0;
      i2c_rdata <= '0;
      spi_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_spi   <= gnt_spi_n;
      last_spi  <= last_spi_n;
      we_q      <= we_n;
      cnt       <= cnt_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wr    <= wr_n;
      reg_rd    <= rd_n;
      i2c_ack   <= i2c_ack_n;
      spi_ack   <= spi_ack_n;
      i2c_rdata <= i2c_rdata_n;
      spi_rdata <= spi_rdata_n;
      busy      <= (state_n != IDLE);
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] gcnt_i2c_q, gcnt_spi_q, ccnt_q;

  // Saturating counters; grant counts step on the same edge the ack rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_i2c_q <= '0;
      gcnt_spi_q <= '0;
      ccnt_q     <= '0;
    end else begin
      if (i2c_ack_n && gcnt_i2c_q != 16'hFFFF) gcnt_i2c_q <= gcnt_i2c_q + 16'd1;
      if (spi_ack_n && gcnt_spi_q != 16'hFFFF) gcnt_spi_q <= gcnt_spi_q + 16'd1;
      if (state == IDLE && i2c_req && spi_req && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 16'd1;
    end
  end

  assign grant_cnt_i2c  = gcnt_i2c_q;
  assign grant_cnt_spi  = gcnt_spi_q;
  assign contention_cnt = ccnt_q;
`else
  assign grant_cnt_i2c  = '0;
  assign grant_cnt_spi  = '0;
  assign contention_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomised bench for regfile_arbiter: a transaction-timing model predicts every output each cycle,
// plus a short directed run on an SPI-priority instance.
module tb_regfile_arbiter;
  localparam int RDL = 3;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_mem = 1'b1;
  always #5 clk = ~clk;

  logic       i2c_req = 1'b0, i2c_we = 1'b0, spi_req = 1'b0, spi_we = 1'b0;
  logic [7:0] i2c_addr = '0, i2c_wdata = '0, spi_addr = '0, spi_wdata = '0;
  logic       i2c_ack, spi_ack, reg_wr, reg_rd, busy;
  logic [7:0] i2c_rdata, spi_rdata, reg_addr, reg_wdata, reg_rdata;
  logic [15:0] gcnt_i2c, gcnt_spi, ccnt;

  regfile_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(RDL), .SPI_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy),
    .grant_cnt_i2c(gcnt_i2c), .grant_cnt_spi(gcnt_spi), .contention_cnt(ccnt)
  );

  // SPI-priority instance with RD_LATENCY=1 and a constant register-file read value.
  logic       p_i2c_req = 1'b0, p_i2c_we = 1'b0, p_spi_req = 1'b0, p_spi_we = 1'b0;
  logic [7:0] p_i2c_addr = '0, p_i2c_wdata = '0, p_spi_addr = '0, p_spi_wdata = '0;
  logic [7:0] p_reg_rdata = 8'h3C;
  logic       p_i2c_ack, p_spi_ack, p_reg_wr, p_reg_rd, p_busy;
  logic [7:0] p_i2c_rdata, p_spi_rdata, p_reg_addr, p_reg_wdata;
  logic [15:0] p_gcnt_i2c, p_gcnt_spi, p_ccnt;

  regfile_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LATENCY(1), .SPI_PRIORITY(1)) dut_pri (
    .clk(clk), .rst(rst),
    .i2c_req(p_i2c_req), .i2c_we(p_i2c_we), .i2c_addr(p_i2c_addr), .i2c_wdata(p_i2c_wdata),
    .i2c_ack(p_i2c_ack), .i2c_rdata(p_i2c_rdata),
    .spi_req(p_spi_req), .spi_we(p_spi_we), .spi_addr(p_spi_addr), .spi_wdata(p_spi_wdata),
    .spi_ack(p_spi_ack), .spi_rdata(p_spi_rdata),
    .reg_addr(p_reg_addr), .reg_wdata(p_reg_wdata), .reg_wr(p_reg_wr), .reg_rd(p_reg_rd),
    .reg_rdata(p_reg_rdata), .busy(p_busy),
    .grant_cnt_i2c(p_gcnt_i2c), .grant_cnt_spi(p_gcnt_spi), .contention_cnt(p_ccnt)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Register-file stand-in: read data appears exactly RDL cycles after the reg_rd pulse, garbage otherwise.
  logic [7:0] env_mem [256];
  logic [7:0] rd_pipe [RDL];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
    end else if (reg_wr) begin
      env_mem[reg_addr] <= reg_wdata;
    end
    rd_pipe[0] <= reg_rd ? env_mem[reg_addr] : 8'hEE;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign reg_rdata = rd_pipe[RDL-1];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transaction model: one outstanding transaction with grant cycle and predicted ack cycle.
  logic [7:0] mdl_mem [256];
  bit         t_valid = 1'b0, t_spi = 1'b0, t_we = 1'b0;
  logic [7:0] t_addr = '0, t_wdata = '0;
  int         t_g = 0, t_ack = 0;
  bit         last_spi_m = 1'b1;
  logic [7:0] exp_rd_i2c = '0, exp_rd_spi = '0;
  int         exp_gi = 0, exp_gs = 0, exp_cc = 0;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_GONE} rq_t;
  rq_t        rq [2];
  logic       r_we [2];
  logic [7:0] r_addr [2], r_wdata [2];

  task automatic p_wait_ack(output logic [1:0] who);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(p_i2c_ack || p_spi_ack) && w < 8);
    who = {p_i2c_ack, p_spi_ack};
  endtask

  initial begin
    bit ack_now, strobe, both, pick, dir_phase, rst_done, post_rst;
    logic acked;
    logic [1:0] who;
    int raise_pct;
    rst_done = 1'b0;
    post_rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
    for (int r = 0; r < 2; r++) begin
      rq[r] = R_IDLE; r_we[r] = 1'b0; r_addr[r] = '0; r_wdata[r] = '0;
    end
    repeat (3) @(negedge clk);

    while (cyc < 3000) begin
      if (cyc > 0) @(negedge clk);
      dir_phase = (cyc < 40);
      raise_pct = dir_phase ? 100 : 30;

      if (t_valid && cyc > t_ack) t_valid = 1'b0;
      ack_now = t_valid && cyc == t_ack;
      if (ack_now) begin
        if (!t_we) begin
          if (t_spi) exp_rd_spi = mdl_mem[t_addr];
          else       exp_rd_i2c = mdl_mem[t_addr];
        end
        if (t_spi) exp_gs++;
        else       exp_gi++;
      end
      strobe = t_valid && cyc == t_g + 1;

      check("i2c_ack", i2c_ack, ack_now && !t_spi);
      check("spi_ack", spi_ack, ack_now && t_spi);
      check("reg_wr", reg_wr, strobe && t_we);
      check("reg_rd", reg_rd, strobe && !t_we);
      if (strobe) begin
        check("reg_addr", reg_addr, t_addr);
        if (t_we) check("reg_wdata", reg_wdata, t_wdata);
      end
      check("busy", busy, t_valid && cyc > t_g && cyc <= t_ack);
      check("i2c_rdata", i2c_rdata, exp_rd_i2c);
      check("spi_rdata", spi_rdata, exp_rd_spi);
      check("grant_cnt_i2c", gcnt_i2c, STATS ? exp_gi : 0);
      check("grant_cnt_spi", gcnt_spi, STATS ? exp_gs : 0);
      check("contention_cnt", ccnt, STATS ? exp_cc : 0);
      if (post_rst) begin
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        post_rst = 1'b0;
      end

      if (rst) begin
        rst = 1'b0;
        init_mem = 1'b0;
        if (rst_done) begin
          rq[0] = R_REQ; r_we[0] = 1'b0; r_addr[0] = 8'($urandom_range(15));
        end
      end else if (!rst_done && cyc >= 1500 && t_valid && !t_we && cyc == t_g + 2) begin
        // Reset lands in the middle of a read's WAIT phase: transaction is dropped without ack.
        rst = 1'b1;
        rst_done = 1'b1;
        post_rst = 1'b1;
        t_valid = 1'b0;
        last_spi_m = 1'b1;
        exp_rd_i2c = '0; exp_rd_spi = '0;
        exp_gi = 0; exp_gs = 0; exp_cc = 0;
        rq[0] = R_IDLE; rq[1] = R_IDLE;
      end else begin
        for (int r = 0; r < 2; r++) begin
          acked = (r == 0) ? i2c_ack : spi_ack;
          if (rq[r] != R_IDLE && acked) begin
            rq[r] = R_IDLE;
          end else if (rq[r] == R_IDLE && cyc >= 1 && $urandom_range(99) < raise_pct) begin
            rq[r]      = R_REQ;
            r_we[r]    = dir_phase ? 1'b1 : 1'($urandom_range(1));
            r_addr[r]  = 8'($urandom_range(15));
            r_wdata[r] = 8'($urandom_range(255));
          end else if (rq[r] == R_REQ && !dir_phase && t_valid && int'(t_spi) == r &&
                       cyc > t_g && $urandom_range(15) == 0) begin
            rq[r] = R_GONE;
          end
        end
      end

      i2c_req = (rq[0] == R_REQ); i2c_we = r_we[0]; i2c_addr = r_addr[0]; i2c_wdata = r_wdata[0];
      spi_req = (rq[1] == R_REQ); spi_we = r_we[1]; spi_addr = r_addr[1]; spi_wdata = r_wdata[1];

      if (!rst && !t_valid && (i2c_req || spi_req)) begin
        both = i2c_req && spi_req;
        pick = both ? !last_spi_m : spi_req;
        t_spi   = pick;
        t_we    = pick ? spi_we    : i2c_we;
        t_addr  = pick ? spi_addr  : i2c_addr;
        t_wdata = pick ? spi_wdata : i2c_wdata;
        t_g     = cyc;
        t_ack   = cyc + (t_we ? 2 : 2 + RDL);
        t_valid = 1'b1;
        last_spi_m = pick;
        if (t_we) mdl_mem[t_addr] = t_wdata;
        if (both) exp_cc++;
      end
      cyc++;
    end
    check("rst_exercised", rst_done, 1);

    // SPI-priority instance: a single SPI read, then a held tie that SPI must keep winning.
    @(negedge clk);
    p_spi_req = 1'b1; p_spi_we = 1'b0; p_spi_addr = 8'h10;
    @(negedge clk);
    check("p_reg_rd", p_reg_rd, 1);
    check("p_reg_addr", p_reg_addr, 8'h10);
    @(negedge clk);
    check("p_early_ack", p_spi_ack, 0);
    @(negedge clk);
    check("p_spi_ack", p_spi_ack, 1);
    check("p_spi_rdata", p_spi_rdata, 8'h3C);
    check("p_i2c_rdata", p_i2c_rdata, 0);
    p_spi_req = 1'b0;
    @(negedge clk);
    p_i2c_req = 1'b1; p_i2c_we = 1'b1; p_i2c_addr = 8'h01; p_i2c_wdata = 8'hA5;
    p_spi_req = 1'b1; p_spi_we = 1'b1; p_spi_addr = 8'h02; p_spi_wdata = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      p_wait_ack(who);
      check("p_spi_wins", who, 2'b01);
    end
    p_spi_req = 1'b0;
    p_wait_ack(who);
    check("p_i2c_turn", who, 2'b10);
    check("p_reg_addr_i2c", p_reg_addr, 8'h01);
    check("p_reg_wdata_i2c", p_reg_wdata, 8'hA5);
    p_i2c_req = 1'b0;
    @(negedge clk);
    check("p_busy_idle", p_busy, 0);
    check("p_reg_wr_idle", p_reg_wr, 0);
    check("p_grant_cnt_i2c", p_gcnt_i2c, STATS ? 1 : 0);
    check("p_grant_cnt_spi", p_gcnt_spi, STATS ? 4 : 0);
    check("p_contention_cnt", p_ccnt, STATS ? 3 : 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Two-requester arbiter that shares the single-port control register file between the I2C control-plane slave and the SPI data-plane slave. Each requester issues read/write transactions over a req/ack handshake. The arbiter serialises them onto the register-file bus (reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata) and returns read data. It sits between the protocol slaves and register_file in top.

Parameters:
ADDR_W, 8, register address width
DATA_W, 8, register data width
RD_LATENCY, 1, clk cycles from reg_rd pulse to valid reg_rdata (1..4)
SPI_PRIORITY, 0, 0 = round-robin; 1 = SPI always wins ties

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i2c_req  in  1  I2C transaction request, held until i2c_ack
i2c_we  in  1  1 = write, 0 = read; stable while i2c_req
i2c_addr  in  ADDR_W  register address
i2c_wdata  in  DATA_W  write data
i2c_ack  out  1  one-cycle completion pulse
i2c_rdata  out  DATA_W  read data, valid with i2c_ack on reads, held until the next I2C read ack
spi_req, spi_we, spi_addr, spi_wdata, spi_ack, spi_rdata  same directions, widths and meanings as the I2C set
reg_addr  out  ADDR_W  register-file address
reg_wdata  out  DATA_W  register-file write data
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read strobe
reg_rdata  in  DATA_W  register-file read data
busy  out  1  high in any state other than IDLE
grant_cnt_i2c, grant_cnt_spi, contention_cnt  out  16 each  statistics (see Optional Feature)

Behaviour:
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE, and last_grant resets to SPI so I2C wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if exactly one req is high, grant it. If both are high: grant SPI when SPI_PRIORITY=1, otherwise grant the requester that is not last_grant. Latch we/addr/wdata and go to ISSUE. With no req, stay in IDLE.
- ISSUE (1 cycle): drive reg_addr. Write: reg_wr=1 and reg_wdata=latched data, then go to ACK. Read: reg_rd=1, load the wait counter with RD_LATENCY, then go to WAIT.
- WAIT: decrement the counter. On the cycle the counter reaches the last count, capture reg_rdata into the granted requester's rdata register, then go to ACK.
- ACK (1 cycle): pulse the granted requester's ack, update last_grant to that requester, return to IDLE.
- Latency from the req-sampled cycle c0: write has reg_wr at c1 and ack at c2. Read has reg_rd at c1 and ack at c2+RD_LATENCY. With RD_LATENCY=1, ack is at c3.
- Requesters drop req the cycle after observing ack. req is sampled only in IDLE, so a request held through ACK is not double-issued.
- If req is withdrawn before ack, the transaction still completes and ack is still pulsed.
- The non-granted requester waits with its req held. There is no starvation: in round-robin mode, worst-case wait is one transaction.
- reg_wr and reg_rd are never high together, and neither is high outside ISSUE.
- The rdata register of the requester that was not granted is unchanged.
- rst mid-transaction: return to IDLE next cycle. All strobes and acks go to 0, the in-flight transaction is dropped with no ack, rdata clears to 0, and last_grant returns to SPI.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: grant_cnt_i2c and grant_cnt_spi increment on each ack to their requester. contention_cnt increments on each IDLE cycle where both req are high and a grant is made. All three are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: all three outputs are tied to 0 and no counter logic is synthesised.

Test Plan:
1. I2C write addr 0x01 data 0xA5, RD_LATENCY=1 -> reg_wr=1 with reg_addr=0x01, reg_wdata=0xA5 at c1; i2c_ack at c2; spi_ack stays 0.
2. SPI read addr 0x10, reg_rdata=0x3C -> reg_rd at c1; spi_ack at c3 with spi_rdata=0x3C; i2c_rdata unchanged.
3. Both req high from reset, round-robin, three back-to-back writes each -> grant order I2C, SPI, I2C, SPI, I2C, SPI; with ARB_STATS_EN, contention_cnt=5 and each grant_cnt=3.
4. SPI_PRIORITY=1, both req held continuously -> SPI granted every transaction until spi_req drops; then I2C granted.
5. rst asserted during WAIT of a read with RD_LATENCY=3 -> no ack; next cycle busy=0, all outputs 0; a following I2C read completes normally at c5.
6. I2C read; i2c_req dropped at c1 -> transaction completes, i2c_ack at c3, no second reg_rd issued.
